vector_dispatch_ctrl: RTL and testbench

Sequences one vector instruction at a time from the instruction execution unit across the `NUM_OF_LANES` parallel lanes of the single-threaded pipeline. It strip-mines the vector length into element groups of `NUM_OF_LANES`, issues each group and collects per-lane completion. It signals writeback once all elements are done and back-pressures the execution unit while an instruction is in flight.

---
 rtl/stp_pkg.sv | 35 +++
 rtl/vector_dispatch_ctrl_if.sv | 38 +++
 rtl/vector_dispatch_ctrl.sv | 113 +++++++++++
 tb/tb_vector_dispatch_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stp_pkg.sv
// Shared single-thread pipeline constants, dispatch state encoding and the lane-mask helper.
// Ports: none (package).
// Consumers import stp_pkg::* for widths, the state enum and gen_lane_mask().
package stp_pkg;

  localparam int NUM_OF_LANES = 4;                    // lanes per element group, power of two
  localparam int MAX_VL       = 64;                   // multiple of NUM_OF_LANES
  localparam int OPCODE_W     = 6;
  localparam int VREG_W       = 5;
  localparam int VL_W         = $clog2(MAX_VL) + 1;   // holds 0..MAX_VL inclusive

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ISSUE,
    DS_WAIT,
    DS_DONE
  } dispatch_state_t;

  // Bit i set iff element elem_base+i lies below vl. One bit of headroom keeps
  // the sum from wrapping even at the top of the VL_W range.
  function automatic logic [NUM_OF_LANES-1:0] gen_lane_mask(
    input logic [VL_W-1:0] elem_base,
    input logic [VL_W-1:0] vl
  );
    logic [NUM_OF_LANES-1:0] mask;
    logic [VL_W:0]           idx;
    mask = '0;
    for (int i = 0; i < NUM_OF_LANES; i++) begin
      idx     = {1'b0, elem_base} + (VL_W+1)'(i);
      mask[i] = (idx < {1'b0, vl});
    end
    return mask;
  endfunction

endpackage

// File: rtl/vector_dispatch_ctrl_if.sv
// Handshake bundle between the execution unit, the lanes, writeback and the dispatch controller.
// Ports: none; slave = controller view, master = environment view (exec unit, lanes, writeback).
// Carries instr_*, lane_issue_*, lane_done, wb_done_* and busy.
interface vector_dispatch_ctrl_if;
  import stp_pkg::*;

  logic                    instr_valid;
  logic                    instr_ready;
  logic [OPCODE_W-1:0]     instr_opcode;
  logic [VREG_W-1:0]       instr_vd;
  logic [VL_W-1:0]         instr_vl;

  logic                    lane_issue_valid;
  logic [NUM_OF_LANES-1:0] lane_issue_mask;
  logic [VL_W-1:0]         lane_issue_elem_base;
  logic [OPCODE_W-1:0]     lane_issue_opcode;
  logic [VREG_W-1:0]       lane_issue_vd;
  logic [NUM_OF_LANES-1:0] lane_done;

  logic                    wb_done_valid;
  logic [VREG_W-1:0]       wb_done_vd;
  logic                    wb_done_ready;

  logic                    busy;

  modport slave (
    input  instr_valid, instr_opcode, instr_vd, instr_vl, lane_done, wb_done_ready,
    output instr_ready, lane_issue_valid, lane_issue_mask, lane_issue_elem_base,
           lane_issue_opcode, lane_issue_vd, wb_done_valid, wb_done_vd, busy
  );

  modport master (
    output instr_valid, instr_opcode, instr_vd, instr_vl, lane_done, wb_done_ready,
    input  instr_ready, lane_issue_valid, lane_issue_mask, lane_issue_elem_base,
           lane_issue_opcode, lane_issue_vd, wb_done_valid, wb_done_vd, busy
  );

endinterface

// File: rtl/vector_dispatch_ctrl.sv
// Strip-mines one vector instruction into NUM_OF_LANES-wide groups, issues each and collects lane completions.
// Ports: clk, reset (async, active-high), dif (slave view of vector_dispatch_ctrl_if).
// Accept->strobe 1 cycle, >=2 cycles per group; instr_ready low while busy, wb_done held until accepted.
module vector_dispatch_ctrl
  import stp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  vector_dispatch_ctrl_if.slave dif
);

  dispatch_state_t         state;
  logic [VL_W-1:0]         vl_q;
  logic [VL_W-1:0]         elem_base;
  logic [NUM_OF_LANES-1:0] done_vec;
  logic [NUM_OF_LANES-1:0] mask_q;
  logic [OPCODE_W-1:0]     opcode_q;
  logic [VREG_W-1:0]       vd_q;
  logic                    issue_valid_q;
  logic                    instr_ready_q;
  logic                    busy_q;
  logic                    wb_valid_q;

  logic [VL_W-1:0]         vl_clamped;
  logic [NUM_OF_LANES-1:0] lane_hit;
  logic                    group_done;
  logic [VL_W-1:0]         base_next;

  assign vl_clamped = (dif.instr_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : dif.instr_vl;
  // Pulses on lanes outside the current group are dropped here.
  assign lane_hit   = dif.lane_done & mask_q;
  // Counts this cycle's pulses so the last lane finishing closes the group immediately.
  assign group_done = ((done_vec | lane_hit) == mask_q);
  assign base_next  = elem_base + VL_W'(NUM_OF_LANES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= DS_IDLE;
      vl_q          <= '0;
      elem_base     <= '0;
      done_vec      <= '0;
      mask_q        <= '0;
      opcode_q      <= '0;
      vd_q          <= '0;
      issue_valid_q <= 1'b0;
      instr_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else begin
      issue_valid_q <= 1'b0;
      case (state)
        DS_IDLE: begin
          if (dif.instr_valid) begin
            opcode_q      <= dif.instr_opcode;
            vd_q          <= dif.instr_vd;
            vl_q          <= vl_clamped;
            elem_base     <= '0;
            done_vec      <= '0;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            if (vl_clamped == '0) begin
              state      <= DS_DONE;
              wb_valid_q <= 1'b1;
            end else begin
              state         <= DS_ISSUE;
              issue_valid_q <= 1'b1;
              mask_q        <= gen_lane_mask('0, vl_clamped);
            end
          end
        end
        DS_ISSUE: begin
          done_vec <= '0;
          state    <= DS_WAIT;
        end
        DS_WAIT: begin
          done_vec <= done_vec | lane_hit;
          if (group_done) begin
            elem_base <= base_next;
            if (base_next >= vl_q) begin
              state      <= DS_DONE;
              wb_valid_q <= 1'b1;
            end else begin
              state         <= DS_ISSUE;
              issue_valid_q <= 1'b1;
              mask_q        <= gen_lane_mask(base_next, vl_q);
            end
          end
        end
        DS_DONE: begin
          if (dif.wb_done_ready) begin
            state         <= DS_IDLE;
            wb_valid_q    <= 1'b0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        default: state <= DS_IDLE;
      endcase
    end
  end

  assign dif.instr_ready          = instr_ready_q;
  assign dif.busy                 = busy_q;
  assign dif.lane_issue_valid     = issue_valid_q;
  assign dif.lane_issue_mask      = mask_q;
  assign dif.lane_issue_elem_base = elem_base;
  assign dif.lane_issue_opcode    = opcode_q;
  assign dif.lane_issue_vd        = vd_q;
  assign dif.wb_done_valid        = wb_valid_q;
  // vd_q only changes on accept, so it is stable for the whole DONE hold.
  assign dif.wb_done_vd           = vd_q;

endmodule

// File: tb/tb_vector_dispatch_ctrl.sv
// Directed bench for vector_dispatch_ctrl with immediate-assertion checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled then or on the falling edge.
// Lanes are driven either by an auto-responder (all masked lanes one cycle after a strobe) or manually.
module tb_vector_dispatch_ctrl;
  import stp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vector_dispatch_ctrl_if vif();

  vector_dispatch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .dif   (vif)
  );

  int n_pass = 0;
  int n_total = 0;

  // Lane drivers
  logic                    auto_on = 1'b0;
  logic [NUM_OF_LANES-1:0] auto_done = '0;
  logic [NUM_OF_LANES-1:0] man_done = '0;
  logic                    seen_strobe = 1'b0;
  logic [NUM_OF_LANES-1:0] seen_mask = '0;
  assign vif.lane_done = auto_done | man_done;

  // Monitor logs
  int              n_strobe = 0;
  int              n_wb = 0;
  logic [VL_W-1:0] base_log[$];
  logic [3:0]      mask_log[$];
  logic [VREG_W-1:0] last_wb_vd = '0;

  always @(negedge clk) begin
    seen_strobe <= vif.lane_issue_valid;
    seen_mask   <= vif.lane_issue_mask;
    if (vif.lane_issue_valid) begin
      n_strobe <= n_strobe + 1;
      base_log.push_back(vif.lane_issue_elem_base);
      mask_log.push_back(4'(vif.lane_issue_mask));
    end
    if (vif.wb_done_valid && vif.wb_done_ready) begin
      n_wb       <= n_wb + 1;
      last_wb_vd <= vif.wb_done_vd;
    end
  end

  always @(posedge clk) begin
    #1;
    auto_done = (auto_on && seen_strobe) ? seen_mask : '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_instr_ready"}, 32'(vif.instr_ready), 1);
    check({tag, "_busy"},        32'(vif.busy), 0);
    check({tag, "_issue_valid"}, 32'(vif.lane_issue_valid), 0);
    check({tag, "_issue_mask"},  32'(vif.lane_issue_mask), 0);
    check({tag, "_issue_base"},  32'(vif.lane_issue_elem_base), 0);
    check({tag, "_issue_opc"},   32'(vif.lane_issue_opcode), 0);
    check({tag, "_issue_vd"},    32'(vif.lane_issue_vd), 0);
    check({tag, "_wb_valid"},    32'(vif.wb_done_valid), 0);
    check({tag, "_wb_vd"},       32'(vif.wb_done_vd), 0);
  endtask

  // Offer one instruction for a single cycle; controller must be in IDLE.
  task automatic send(input logic [OPCODE_W-1:0] opc, input logic [VREG_W-1:0] vd,
                      input logic [VL_W-1:0] vl);
    vif.instr_valid  = 1'b1;
    vif.instr_opcode = opc;
    vif.instr_vd     = vd;
    vif.instr_vl     = vl;
    tick();
    vif.instr_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && !vif.instr_ready; i++) tick();
    check({tag, "_idle_in_budget"}, 32'(vif.instr_ready), 1);
  endtask

  int s0;
  int w0;

  initial begin
    vif.instr_valid   = 1'b0;
    vif.instr_opcode  = '0;
    vif.instr_vd      = '0;
    vif.instr_vl      = '0;
    vif.wb_done_ready = 1'b1;
    #2 reset = 1'b1;
    tick();
    check_reset("por");
    reset = 1'b0;
    tick();

    // vl=4: single full group, lanes answer in WAIT's first cycle.
    auto_on = 1'b1;
    s0 = n_strobe; w0 = n_wb;
    send(6'h15, 5'd7, 7'd4);
    check("vl4_strobe",      32'(vif.lane_issue_valid), 1);
    check("vl4_mask",        32'(vif.lane_issue_mask), 4'hF);
    check("vl4_base",        32'(vif.lane_issue_elem_base), 0);
    check("vl4_opc",         32'(vif.lane_issue_opcode), 6'h15);
    check("vl4_vd",          32'(vif.lane_issue_vd), 7);
    check("vl4_busy",        32'(vif.busy), 1);
    check("vl4_ready_low",   32'(vif.instr_ready), 0);
    tick();
    check("vl4_wait_nostrobe", 32'(vif.lane_issue_valid), 0);
    check("vl4_wait_nowb",   32'(vif.wb_done_valid), 0);
    tick();
    check("vl4_wb_valid",    32'(vif.wb_done_valid), 1);
    check("vl4_wb_vd",       32'(vif.wb_done_vd), 7);
    tick();
    check("vl4_idle_ready",  32'(vif.instr_ready), 1);
    check("vl4_idle_wb",     32'(vif.wb_done_valid), 0);
    check("vl4_idle_busy",   32'(vif.busy), 0);
    check("vl4_nstrobe",     32'(n_strobe - s0), 1);
    check("vl4_nwb",         32'(n_wb - w0), 1);

    // vl=10: three groups, last one partial.
    s0 = n_strobe; w0 = n_wb;
    send(6'h03, 5'd11, 7'd10);
    wait_idle("vl10", 40);
    check("vl10_nstrobe", 32'(n_strobe - s0), 3);
    if (n_strobe - s0 >= 3) begin
      check("vl10_base0", 32'(base_log[s0]),   0);
      check("vl10_base1", 32'(base_log[s0+1]), 4);
      check("vl10_base2", 32'(base_log[s0+2]), 8);
      check("vl10_mask0", 32'(mask_log[s0]),   4'hF);
      check("vl10_mask1", 32'(mask_log[s0+1]), 4'hF);
      check("vl10_mask2", 32'(mask_log[s0+2]), 4'h3);
    end
    check("vl10_nwb",   32'(n_wb - w0), 1);
    check("vl10_wb_vd", 32'(last_wb_vd), 11);

    // vl=3: lanes finish out of order with a spurious pulse on unmasked lane 3,
    // then writeback stalls while a vl=0 instruction waits.
    auto_on = 1'b0;
    vif.wb_done_ready = 1'b0;
    s0 = n_strobe; w0 = n_wb;
    send(6'h2A, 5'd3, 7'd3);
    check("ooo_mask", 32'(vif.lane_issue_mask), 4'h7);
    tick(); man_done = 4'b1000;
    tick(); check("ooo_hold1", 32'(vif.wb_done_valid), 0);
            check("ooo_nostrobe", 32'(vif.lane_issue_valid), 0);
            man_done = 4'b0010;
    tick(); check("ooo_hold2", 32'(vif.wb_done_valid), 0); man_done = 4'b0100;
    tick(); check("ooo_hold3", 32'(vif.wb_done_valid), 0); man_done = 4'b0000;
    tick(); check("ooo_hold4", 32'(vif.wb_done_valid), 0); man_done = 4'b0001;
    tick(); man_done = 4'b0000;
    check("ooo_wb_valid", 32'(vif.wb_done_valid), 1);
    check("ooo_wb_vd",    32'(vif.wb_done_vd), 3);
    vif.instr_valid  = 1'b1;
    vif.instr_opcode = 6'h02;
    vif.instr_vd     = 5'd9;
    vif.instr_vl     = 7'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_wb_valid", 32'(vif.wb_done_valid), 1);
      check("stall_wb_vd",    32'(vif.wb_done_vd), 3);
      check("stall_ready",    32'(vif.instr_ready), 0);
    end
    vif.wb_done_ready = 1'b1;
    tick();
    check("post_hs_wb_valid", 32'(vif.wb_done_valid), 0);
    check("post_hs_ready",    32'(vif.instr_ready), 1);
    tick();
    vif.instr_valid = 1'b0;
    check("vl0_wb_valid",  32'(vif.wb_done_valid), 1);
    check("vl0_wb_vd",     32'(vif.wb_done_vd), 9);
    check("vl0_nostrobe",  32'(vif.lane_issue_valid), 0);
    tick();
    check("vl0_idle",      32'(vif.instr_ready), 1);
    check("ooo_vl0_nstrobe", 32'(n_strobe - s0), 1);
    check("ooo_vl0_nwb",     32'(n_wb - w0), 2);

    // vl=100 clamps to 64: 16 groups.
    auto_on = 1'b1;
    s0 = n_strobe; w0 = n_wb;
    send(6'h11, 5'd30, 7'd100);
    wait_idle("vl100", 100);
    check("vl100_nstrobe", 32'(n_strobe - s0), 16);
    if (n_strobe - s0 >= 16) begin
      check("vl100_last_base", 32'(base_log[s0+15]), 60);
      check("vl100_last_mask", 32'(mask_log[s0+15]), 4'hF);
    end
    check("vl100_nwb", 32'(n_wb - w0), 1);

    // Reset during WAIT of group 2 drops the instruction.
    auto_on = 1'b0;
    w0 = n_wb;
    send(6'h01, 5'd12, 7'd10);
    tick(); man_done = 4'hF;
    tick(); man_done = 4'h0;
    check("rst_g2_strobe", 32'(vif.lane_issue_valid), 1);
    check("rst_g2_base",   32'(vif.lane_issue_elem_base), 4);
    tick();
    #2 reset = 1'b1;
    #1 check_reset("async");
    tick();
    reset = 1'b0;
    tick();
    check("rst_no_wb", 32'(n_wb - w0), 0);
    auto_on = 1'b1;
    s0 = n_strobe; w0 = n_wb;
    send(6'h05, 5'd20, 7'd4);
    check("fresh_mask", 32'(vif.lane_issue_mask), 4'hF);
    check("fresh_base", 32'(vif.lane_issue_elem_base), 0);
    check("fresh_opc",  32'(vif.lane_issue_opcode), 6'h05);
    wait_idle("fresh", 20);
    check("fresh_nstrobe", 32'(n_strobe - s0), 1);
    check("fresh_nwb",     32'(n_wb - w0), 1);
    check("fresh_wb_vd",   32'(last_wb_vd), 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
